gate_vec_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-bit two-input gate primitives.
- Applies one of eight bitwise gate functions to WIDTH-bit operand vectors.
- Results pass through STAGES register stages under valid/ready flow control.
- Adds an accumulate mode that folds a multi-beat packet into a single result. It sits between operand producers and any downstream consumer that may stall.

---
 rtl/gate_vec_pipe.sv | 136 +++++++++++++
 tb/tb_gate_vec_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vec_pipe.sv
// gate_vec_pipe: applies one of eight bitwise gate functions to WIDTH-bit
// operands and carries the result through STAGES valid/ready pipeline stages.
// An accumulate mode folds a multi-beat packet into a single result, chaining
// each beat's result into the B operand of the next beat.
module gate_vec_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_last
);

  // Bitwise gate selected by op; no carries between bit positions.
  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0]       sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x & ~y;
      default: r = x;
    endcase
    return r;
  endfunction

  // Packet tracking state.
  logic             first_q, first_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Pipeline stages; the last stage drives the outputs directly.
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            lst_q, lst_d;
  logic [STAGES-1:0][WIDTH-1:0] dat_q, dat_d;

  logic             advance;
  logic             accept;
  logic             cur_mode;
  logic             use_acc;
  logic             emit;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] result;

  // Handshake and datapath for the beat currently presented at the input.
  always_comb begin
    advance  = !vld_q[STAGES-1] || out_ready;
    accept   = in_valid && advance;
    // The first beat of a packet uses its own acc_mode; later beats use the
    // mode latched on that first beat.
    cur_mode = first_q ? acc_mode : mode_q;
    use_acc  = cur_mode && !first_q;
    opnd_b   = use_acc ? acc_q : b;
    result   = gate_f(op, a, opnd_b);
    // Non-last accumulate beats only update the accumulator.
    emit     = accept && (!cur_mode || in_last);
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign out_last  = lst_q[STAGES-1];
  assign out       = dat_q[STAGES-1];

  // Next-state for the first flag, held mode and accumulator.
  always_comb begin
    first_d = first_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    if (accept) begin
      first_d = in_last;
      acc_d   = result;
      if (first_q) begin
        mode_d = acc_mode;
      end
    end
  end

  // Next-state for the pipeline: shift on advance, hold everything otherwise.
  always_comb begin
    vld_d = vld_q;
    lst_d = lst_q;
    dat_d = dat_q;
    if (advance) begin
      vld_d[0] = emit;
      lst_d[0] = in_last;
      dat_d[0] = result;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        lst_d[i] = lst_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // Packet tracking registers; reset discards any partial accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      mode_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      first_q <= first_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
    end
  end

  // Pipeline registers; reset flushes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      lst_q <= lst_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: tb/tb_gate_vec_pipe.sv
// Testbench for gate_vec_pipe: directed scenarios plus randomized traffic,
// checked every cycle against a packet-level reference model.
module tb_gate_vec_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic             acc_mode = 1'b0;
  logic             in_last = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out;
  logic             out_last;

  gate_vec_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_mode(acc_mode), .in_last(in_last),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit check_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: expected results queued in acceptance order.
  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
    int               c;
    bit               lat;
  } item_t;

  item_t            exp_q[$];
  logic [WIDTH:0]   got_q[$];
  bit               m_first = 1;
  bit               m_mode  = 0;
  logic [WIDTH-1:0] m_acc   = '0;

  function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] s,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    for (int k = 0; k < WIDTH; k++) begin
      case (s)
        3'd0: r[k] = x[k] && y[k];
        3'd1: r[k] = x[k] || y[k];
        3'd2: r[k] = x[k] != y[k];
        3'd3: r[k] = !(x[k] && y[k]);
        3'd4: r[k] = !(x[k] || y[k]);
        3'd5: r[k] = x[k] == y[k];
        3'd6: r[k] = x[k] && !y[k];
        default: r[k] = x[k];
      endcase
    end
    return r;
  endfunction

  // Compare process: every falling edge, check outputs and advance the model.
  bit               prev_stall = 0;
  logic [WIDTH-1:0] prev_out;
  logic             prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_first = 1; m_mode = 0; m_acc = '0;
      prev_stall = 0;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out", {24'd0, out}, 32'd0);
      chk("reset_out_last", {31'd0, out_last}, 32'd0);
    end else begin
      item_t it;
      logic [WIDTH-1:0] opnd;
      logic [WIDTH-1:0] r;
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (prev_stall) begin
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_out", {24'd0, out}, {24'd0, prev_out});
        chk("stall_out_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", {24'd0, out}, 32'hFFFF_FFFF);
        end else begin
          it = exp_q.pop_front();
          chk("out", {24'd0, out}, {24'd0, it.d});
          chk("out_last", {31'd0, out_last}, {31'd0, it.l});
          if (it.lat && check_lat) chk("latency", cyc - it.c, STAGES);
          got_q.push_back({out_last, out});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        if (m_first) m_mode = acc_mode;
        opnd  = (m_mode && !m_first) ? m_acc : b;
        r     = ref_gate(op, a, opnd);
        m_acc = r;
        if (!m_mode || in_last) begin
          it.d = r; it.l = in_last; it.c = cyc; it.lat = check_lat;
          exp_q.push_back(it);
        end
        m_first = in_last;
      end
    end
  end

  // Offer one beat and wait (bounded) until it is accepted.
  task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] av,
                      input logic [WIDTH-1:0] bv, input logic l, input logic m);
    bit done = 0;
    op = o; a = av; b = bv; in_last = l; acc_mode = m; in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (STAGES + 4) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic chk_got(input string name, input int idx,
                         input logic [WIDTH-1:0] d, input logic l);
    if (idx >= got_q.size()) chk(name, 32'hDEAD, {23'd0, l, d});
    else chk(name, {23'd0, got_q[idx]}, {23'd0, l, d});
  endtask

  logic [WIDTH-1:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};

    // 1. Reset with in_valid held high.
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h55; b = 8'hAA;
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 2. Op sweep with latency checks.
    got_q.delete(); check_lat = 1;
    for (int i = 0; i < 8; i++) send(i[2:0], 8'hF0, 8'hCC, 1'b1, 1'b0);
    drain(); check_lat = 0;
    chk("sweep_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk_got("sweep_val", i, sweep_exp[i], 1'b1);

    // 3. Backpressure: third beat must be held until out_ready rises.
    got_q.delete(); out_ready = 1'b0;
    send(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    send(3'd0, 8'hFF, 8'h02, 1'b1, 1'b0);
    fork
      send(3'd0, 8'hFF, 8'h03, 1'b1, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", got_q.size(), 32'd3);
    chk_got("bp_val0", 0, 8'h01, 1'b1);
    chk_got("bp_val1", 1, 8'h02, 1'b1);
    chk_got("bp_val2", 2, 8'h03, 1'b1);

    // 4. AND accumulate.
    got_q.delete();
    send(3'd0, 8'hFF, 8'h0F, 1'b0, 1'b1);
    send(3'd0, 8'h3C, 8'h00, 1'b0, 1'b0);
    send(3'd0, 8'hF5, 8'h00, 1'b1, 1'b0);
    drain();
    chk("acc_count", got_q.size(), 32'd1);
    chk_got("acc_and", 0, 8'h04, 1'b1);

    // 5. Mixed-op accumulate followed by a normal beat.
    got_q.delete();
    send(3'd2, 8'h01, 8'h02, 1'b0, 1'b1);
    send(3'd2, 8'h04, 8'h77, 1'b0, 1'b0);
    send(3'd1, 8'h08, 8'h77, 1'b1, 1'b1);
    send(3'd0, 8'hAA, 8'h0F, 1'b1, 1'b0);
    drain();
    chk("mix_count", got_q.size(), 32'd2);
    chk_got("mix_acc", 0, 8'h0F, 1'b1);
    chk_got("mix_normal", 1, 8'h0A, 1'b1);

    // 6. Reset in the middle of an accumulate packet.
    got_q.delete();
    send(3'd0, 8'hFF, 8'h0F, 1'b0, 1'b1);
    send(3'd0, 8'h3C, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    send(3'd1, 8'h10, 8'h01, 1'b1, 1'b0);
    drain();
    chk("midrst_count", got_q.size(), 32'd1);
    chk_got("midrst_val", 0, 8'h11, 1'b1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      acc_mode  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    drain();
    @(negedge clk);
    chk("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
